// File: rtl/image_pixel_streamer.sv
// rtl/image_pixel_streamer.sv - fetches a packed 8-bit image and streams one signed pixel per cycle
module image_pixel_streamer #(
    parameter int TOTAL_PIXELS = 1024,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               base_addr,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            mem_read,
    input  logic [31:0]                     mem_rdata,
    output logic                            pixel_valid,
    output logic signed [7:0]               pixel_out,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(TOTAL_PIXELS):0]   pixel_count
);

    localparam int PTR_W = $clog2(TOTAL_PIXELS);
    localparam int CNT_W = $clog2(TOTAL_PIXELS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE_S
    } state_t;

    state_t                               state;
    logic [ADDR_W-1:0]                    base_latched;
    logic [PTR_W-1:0]                     ptr;
    logic [PTR_W-1:0]                     next_ptr;
    logic [ADDR_W-1:0]                    next_offset;
    logic                                 last_ptr;
    logic                                 tags_empty;
    logic [READ_LATENCY-1:0]              tag_valid;
    logic [READ_LATENCY-1:0][1:0]         tag_sel;
    logic [7:0]                           aligned_byte;

    // Next request address: the word holding the following pixel (low two bits cleared).
    always_comb begin
        next_ptr    = ptr + PTR_W'(1);
        next_offset = ADDR_W'(next_ptr) & ~ADDR_W'(3);
        last_ptr    = (ptr == PTR_W'(TOTAL_PIXELS - 1));
        tags_empty  = ~|tag_valid;
    end

    // Little-endian byte pick driven by the tag that lines up with the returning read data.
    always_comb begin
        aligned_byte = mem_rdata[7:0];
        case (tag_sel[READ_LATENCY-1])
            2'd0:    aligned_byte = mem_rdata[7:0];
            2'd1:    aligned_byte = mem_rdata[15:8];
            2'd2:    aligned_byte = mem_rdata[23:16];
            default: aligned_byte = mem_rdata[31:24];
        endcase
    end

    // Tag pipeline: follows each request through the bridge so in-flight reads can be matched.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_sel   <= '0;
        end else begin
            tag_valid[0] <= mem_read;
            tag_sel[0]   <= ptr[1:0];
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_sel[i]   <= tag_sel[i-1];
            end
        end
    end

    // Control FSM with registered request, pixel and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base_latched <= '0;
            ptr          <= '0;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            pixel_valid  <= 1'b0;
            pixel_out    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pixel_count  <= '0;
        end else begin
            done        <= 1'b0;
            pixel_valid <= tag_valid[READ_LATENCY-1];
            if (tag_valid[READ_LATENCY-1]) begin
                pixel_out <= aligned_byte;
                if (pixel_count != CNT_W'(TOTAL_PIXELS)) begin
                    pixel_count <= pixel_count + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= FETCH;
                        base_latched <= base_addr & ~ADDR_W'(3);
                        ptr          <= '0;
                        pixel_count  <= '0;
                        mem_addr     <= base_addr & ~ADDR_W'(3);
                        mem_read     <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                FETCH: begin
                    if (last_ptr) begin
                        state    <= DRAIN;
                        mem_read <= 1'b0;
                    end else begin
                        ptr      <= next_ptr;
                        mem_addr <= base_latched + next_offset;
                    end
                end
                DRAIN: begin
                    // Last pixel is on the output this cycle once nothing remains in flight.
                    if (tags_empty && pixel_valid) begin
                        state <= DONE_S;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_pixel_streamer.sv
// tb/tb_image_pixel_streamer.sv - self-checking bench for image_pixel_streamer
module tb_image_pixel_streamer;

    localparam int T  = 1024;
    localparam int CW = $clog2(T) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_a, start_b;
    logic [31:0]   base_addr;
    logic [31:0]   mem_addr_a, mem_addr_b, mem_rdata_a, mem_rdata_b;
    logic          mem_read_a, mem_read_b;
    logic          pixel_valid_a, pixel_valid_b;
    logic [7:0]    pixel_out_a, pixel_out_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [CW-1:0] count_a, count_b;

    image_pixel_streamer #(.TOTAL_PIXELS(T), .READ_LATENCY(2), .ADDR_W(32)) u_lat2 (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr),
        .mem_addr(mem_addr_a), .mem_read(mem_read_a), .mem_rdata(mem_rdata_a),
        .pixel_valid(pixel_valid_a), .pixel_out(pixel_out_a),
        .busy(busy_a), .done(done_a), .pixel_count(count_a)
    );

    image_pixel_streamer #(.TOTAL_PIXELS(T), .READ_LATENCY(4), .ADDR_W(32)) u_lat4 (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr),
        .mem_addr(mem_addr_b), .mem_read(mem_read_b), .mem_rdata(mem_rdata_b),
        .pixel_valid(pixel_valid_b), .pixel_out(pixel_out_b),
        .busy(busy_b), .done(done_b), .pixel_count(count_b)
    );

    // Memory image: byte at address a holds a mod 256.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b0;
        b0 = a[7:0] & 8'hFC;
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    function automatic logic [7:0] exp_pix(input logic [31:0] b, input int k);
        logic [31:0] s;
        s = b + 32'(k);
        return s[7:0];
    endfunction

    logic [31:0] hist_a [2];
    logic [31:0] hist_b [4];

    always @(posedge clk) begin
        hist_a[0] <= mem_addr_a;
        hist_a[1] <= hist_a[0];
        hist_b[0] <= mem_addr_b;
        for (int i = 1; i < 4; i++) hist_b[i] <= hist_b[i-1];
    end

    assign mem_rdata_a = word_at(hist_a[1]);
    assign mem_rdata_b = word_at(hist_b[3]);

    typedef struct {
        int          dut;
        logic [31:0] base;
        int          restart_at;
        logic [31:0] restart_base;
        int          rst_at;
        bit          chain;
        int          exp_first;
        int          exp_done;
        int          exp_valids;
        int          exp_count;
    } row_t;

    row_t rows [10];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic row_t mk(input int dut, input logic [31:0] base, input int restart_at,
                                input logic [31:0] rb, input int rst_at, input bit chain);
        row_t w;
        int   lat;
        lat            = (dut != 0) ? 4 : 2;
        w.dut          = dut;
        w.base         = base;
        w.restart_at   = restart_at;
        w.restart_base = rb;
        w.rst_at       = rst_at;
        w.chain        = chain;
        w.exp_first    = 2 + lat;
        w.exp_done     = (rst_at >= 0) ? -1 : 2 + lat + T;
        w.exp_valids   = (rst_at >= 0) ? rst_at - 1 - lat : T;
        w.exp_count    = (rst_at >= 0) ? 0 : T;
        return w;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic run_row(input int r);
        row_t          w;
        int            lat, first, nvalid, ndone, done_cyc;
        int            pix_err, ctrl_err, addr_err, cnt_err, exp_cnt;
        bit            alive, exp_busy, exp_read;
        logic          s_pv, s_busy, s_done, s_read;
        logic [7:0]    s_po;
        logic [31:0]   s_addr, b;
        logic [CW-1:0] s_cnt;
        w        = rows[r];
        lat      = (w.dut != 0) ? 4 : 2;
        b        = w.base & ~32'd3;
        first    = -1;
        done_cyc = -1;
        nvalid   = 0;
        ndone    = 0;
        pix_err  = 0;
        ctrl_err = 0;
        addr_err = 0;
        cnt_err  = 0;
        s_cnt    = '0;
        if (!w.chain) repeat (3) @(posedge clk);
        for (int n = 0; n <= 2 + lat + T; n++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
            rst     = 1'b0;
            if (n == 0 || n == w.restart_at) begin
                if (w.dut != 0) start_b = 1'b1;
                else            start_a = 1'b1;
                base_addr = (n == 0) ? w.base : w.restart_base;
            end
            if (n == w.rst_at) rst = 1'b1;
            @(negedge clk);
            s_pv   = (w.dut != 0) ? pixel_valid_b : pixel_valid_a;
            s_po   = (w.dut != 0) ? pixel_out_b   : pixel_out_a;
            s_busy = (w.dut != 0) ? busy_b        : busy_a;
            s_done = (w.dut != 0) ? done_b        : done_a;
            s_read = (w.dut != 0) ? mem_read_b    : mem_read_a;
            s_addr = (w.dut != 0) ? mem_addr_b    : mem_addr_a;
            s_cnt  = (w.dut != 0) ? count_b       : count_a;

            alive    = (w.rst_at < 0) || (n <= w.rst_at);
            exp_busy = alive && n >= 1 && n <= 1 + lat + T;
            exp_read = alive && n >= 1 && n <= T;

            if (s_busy !== exp_busy) ctrl_err++;
            if (s_read !== exp_read) addr_err++;
            else if (exp_read && s_addr !== b + 32'((n - 1) & ~3)) addr_err++;
            if (s_done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (s_pv === 1'b1) begin
                if (first < 0) first = n;
                if (n != 2 + lat + nvalid || s_po !== exp_pix(b, nvalid)) pix_err++;
                nvalid++;
            end else if (alive && nvalid > 0 && s_po !== exp_pix(b, nvalid - 1)) begin
                pix_err++;
            end
            if (n >= 1) begin
                exp_cnt = alive ? nvalid : 0;
                if (s_cnt !== CW'(exp_cnt)) cnt_err++;
            end
        end
        check($sformatf("row%0d first_valid_cycle", r), first, w.exp_first);
        check($sformatf("row%0d valid_count", r), nvalid, w.exp_valids);
        check($sformatf("row%0d done_cycle", r), done_cyc, w.exp_done);
        check($sformatf("row%0d done_pulses", r), ndone, (w.rst_at >= 0) ? 0 : 1);
        check($sformatf("row%0d pixel_errors", r), pix_err, 0);
        check($sformatf("row%0d busy_errors", r), ctrl_err, 0);
        check($sformatf("row%0d addr_errors", r), addr_err, 0);
        check($sformatf("row%0d count_errors", r), cnt_err, 0);
        check($sformatf("row%0d final_count", r), s_cnt, w.exp_count);
    endtask

    initial begin
        int e;
        rst       = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        base_addr = '0;

        rows[0] = mk(0, 32'h0000_0000, -1, 32'h0, -1, 1'b0);
        rows[1] = mk(0, 32'h0000_1003, -1, 32'h0, -1, 1'b0);
        rows[2] = mk(1, 32'h0000_0000, -1, 32'h0, -1, 1'b0);
        rows[3] = mk(0, 32'h0000_2000, 500, 32'h0000_5550, -1, 1'b0);
        rows[4] = mk(0, 32'h0000_0040, -1, 32'h0, 300, 1'b0);
        rows[5] = mk(0, 32'h0000_0080, -1, 32'h0, -1, 1'b0);
        rows[6] = mk(0, 32'h0000_0300, -1, 32'h0, -1, 1'b1);
        for (int r = 7; r < 10; r++) begin
            rows[r] = mk(int'($urandom_range(0, 1)), $urandom,
                         ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 1000)) : -1,
                         $urandom, -1, 1'b0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pixel_valid_a", pixel_valid_a, 0);
        check("reset pixel_out_a", pixel_out_a, 0);
        check("reset busy_a", busy_a, 0);
        check("reset done_a", done_a, 0);
        check("reset mem_read_a", mem_read_a, 0);
        check("reset mem_addr_a", mem_addr_a, 0);
        check("reset count_a", count_a, 0);
        check("reset pixel_valid_b", pixel_valid_b, 0);
        check("reset busy_b", busy_b, 0);
        check("reset mem_read_b", mem_read_b, 0);
        check("reset count_b", count_b, 0);

        @(posedge clk);
        #1;
        rst       = 1'b1;
        start_a   = 1'b1;
        start_b   = 1'b1;
        base_addr = 32'h0000_0100;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        e       = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy_a || busy_b || mem_read_a || mem_read_b || pixel_valid_a || pixel_valid_b) e++;
        end
        check("start_with_rst_stays_idle", e, 0);

        for (int r = 0; r < 10; r++) run_row(r);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/image_pixel_streamer.md
Name: image_pixel_streamer

Overview:
- Upstream feeder for the C1 convolution stage.
- Reads one packed 8-bit image (4 pixels per 32-bit word) from the HPS-shared on-chip memory through the fixed-latency bridge read port.
- Unpacks bytes in little-endian order and streams exactly TOTAL_PIXELS signed pixels, one per cycle with no gaps, as data_valid_in/pixel_in to the conv front end.
- Replaces ad-hoc byte-select pipelines in top-level wrappers with one verified block.

Parameters:
- TOTAL_PIXELS, 1024: pixels per image; must be a multiple of 4.
- READ_LATENCY, 2: cycles from mem_addr presented to matching mem_rdata; 1..4.
- ADDR_W, 32: width of the byte address.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to stream one image
- base_addr  in  ADDR_W  byte address of the image; sampled with start; bits[1:0] ignored
- mem_addr  out  ADDR_W  word-aligned byte address to the bridge
- mem_read  out  1  high when mem_addr carries a live request
- mem_rdata  in  32  read data, valid READ_LATENCY cycles after its address
- pixel_valid  out  1  pixel_out valid this cycle
- pixel_out  out  8  signed pixel, byte (p mod 4) of word p/4
- busy  out  1  high from the first fetch cycle through the last valid pixel
- done  out  1  one-cycle pulse the cycle after the last valid pixel
- pixel_count  out  clog2(TOTAL_PIXELS)+1  pixels emitted in the current or last run

Behaviour:
- Reset values: all outputs 0; state IDLE; all internal tag pipeline stages invalid.
- States:
  - IDLE -> FETCH on start; latches base_addr & ~3 and clears ptr and pixel_count.
  - FETCH: issues one request per cycle for pixel ptr; ptr increments each cycle. After the request for ptr = TOTAL_PIXELS-1 is issued, the block moves to DRAIN.
  - DRAIN: waits until the tag pipeline is empty and the last pixel has been emitted, then moves to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Addressing in FETCH:
  - mem_addr = base_latched + {ptr[..2], 2'b00}; mem_read = 1.
  - The same word is re-requested for 4 consecutive cycles; no word cache.
  - Outside FETCH: mem_read = 0 and mem_addr holds its last value.
- Tag pipeline: READ_LATENCY stages carrying {valid, ptr[1:0]}, aligned with mem_rdata. The byte mux uses the aligned tag, and its result is registered into pixel_out/pixel_valid, adding +1 cycle.
- Timing, with start sampled at cycle 0:
  - Request for pixel p is presented in cycle 1+p.
  - pixel_valid for pixel p is high in cycle 2+READ_LATENCY+p; first pixel at cycle 4 with default parameters.
  - Last pixel is in cycle 1+READ_LATENCY+TOTAL_PIXELS.
  - done pulses at cycle 2+READ_LATENCY+TOTAL_PIXELS.
  - busy is high in cycles 1 .. 1+READ_LATENCY+TOTAL_PIXELS.
- pixel_count increments on every pixel_valid, saturates at TOTAL_PIXELS, and holds its value until the next accepted start.
- pixel_out is a raw byte reinterpreted as signed; no arithmetic is applied. pixel_out holds its last value when pixel_valid=0.
- start while busy or in DONE is ignored: no restart and no latch of base_addr.
- start in the same cycle as rst: rst wins, and the block stays in IDLE.
- rst mid-stream: the next cycle has pixel_valid=0, mem_read=0, busy=0, no done, and all tags are cleared. Data from in-flight reads is discarded.
- A start accepted in the cycle after done is legal; back-to-back images are separated by 1 idle cycle minimum.
- No backpressure: the downstream stage must accept one pixel per cycle.

Test Plan:
- Memory model at latency 2, word k = {4k+3, 4k+2, 4k+1, 4k} mod 256; start with base 0x0:
  - Pixels p = 0..1023 equal p mod 256 (as signed), on consecutive cycles starting at cycle 4.
  - done at cycle 1028; pixel_count = 1024.
- base_addr = 0x1003 -> mem_addr sequence starts 0x1000, 0x1000, 0x1000, 0x1000, 0x1004; last address is 0x13FC.
- READ_LATENCY = 4 with the same image -> first pixel_valid at cycle 6, done at cycle 1030, data identical to the first scenario.
- start pulsed again at cycle 500 of a run -> ignored; exactly 1024 valids and one done; base unchanged.
- rst asserted at cycle 300 -> pixel_valid=0 and busy=0 from cycle 301, no done. A new start then streams a full correct image with pixel_count restarting at 0.
- Two starts at cycles 0 and 1029 (the cycle after done) -> two complete 1024-pixel streams with exactly one gap cycle between them.
